// File: rtl/lfu_replacement_ctrl_if.sv
// lfu_replacement_ctrl_if: access-report handshake and completion response between cache FSM and LFU controller
interface lfu_replacement_ctrl_if #(
  parameter int bitsDirect = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic [bitsDirect-1:0] req_address;
  logic                  req_hit;
  logic [3:0]            req_hit_way;
  logic                  flush;
  logic                  done;
  logic                  resp_miss;
  logic [3:0]            victim_way;
  modport master (
    output req_valid, req_address, req_hit, req_hit_way, flush,
    input  req_ready, done, resp_miss, victim_way
  );
  modport slave (
    input  req_valid, req_address, req_hit, req_hit_way, flush,
    output req_ready, done, resp_miss, victim_way
  );
endinterface

// File: rtl/lfu_replacement_ctrl.sv
// lfu_replacement_ctrl: sequences read/increment/victim-clear of a 4-way LFU counter bank
module lfu_replacement_ctrl #(
  parameter int bitsDirect  = 10,
  parameter int sizeCounter = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  lfu_replacement_ctrl_if.slave  bus,
  output logic                   cnt_enable_o,
  output logic [3:0]             cnt_line_reset_o,
  output logic [3:0]             cnt_line_sum_o,
  output logic [bitsDirect-1:0]  cnt_address_o,
  output logic                   cnt_read_o,
  output logic                   cnt_gen_reset_o,
  input  logic [sizeCounter-1:0] count_in0_i,
  input  logic [sizeCounter-1:0] count_in1_i,
  input  logic [sizeCounter-1:0] count_in2_i,
  input  logic [sizeCounter-1:0] count_in3_i
);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_FLUSH, S_READ, S_WAIT, S_UPDATE, S_RESP} state_t;
  state_t                  state_q;
  logic                    ready_q, done_q, resp_miss_q, en_q, read_q, gen_q, miss_q;
  logic [3:0]              victim_way_q, line_reset_q, line_sum_q, way_q, touched_q;
  logic [bitsDirect-1:0]   addr_q;
  logic [3:0]              way_d, victim_d;
  logic [sizeCounter-1:0]  hit_cnt_d, v01_d, v23_d;
  logic                    lo01_d, lo23_d, sat_d;
  // Hit-way normalisation, saturation test and min-count victim search (ties to lower index)
  always_comb begin
    way_d     = bus.req_hit_way & (~bus.req_hit_way + 4'd1);
    hit_cnt_d = ({sizeCounter{way_q[0]}} & count_in0_i) | ({sizeCounter{way_q[1]}} & count_in1_i)
              | ({sizeCounter{way_q[2]}} & count_in2_i) | ({sizeCounter{way_q[3]}} & count_in3_i);
    sat_d     = &hit_cnt_d;
    lo01_d    = count_in1_i < count_in0_i;
    lo23_d    = count_in3_i < count_in2_i;
    v01_d     = lo01_d ? count_in1_i : count_in0_i;
    v23_d     = lo23_d ? count_in3_i : count_in2_i;
    victim_d  = (v23_d < v01_d) ? (lo23_d ? 4'b1000 : 4'b0100) : (lo01_d ? 4'b0010 : 4'b0001);
  end
  // Controller FSM; every output is registered for the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_INIT;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      resp_miss_q  <= 1'b0;
      victim_way_q <= '0;
      en_q         <= 1'b0;
      line_reset_q <= '0;
      line_sum_q   <= '0;
      addr_q       <= '0;
      read_q       <= 1'b0;
      gen_q        <= 1'b1;
      miss_q       <= 1'b0;
      way_q        <= '0;
      touched_q    <= '0;
    end else begin
      case (state_q)
        S_INIT, S_FLUSH: begin
          state_q <= S_IDLE;
          gen_q   <= 1'b0;
          ready_q <= 1'b1;
        end
        S_IDLE: begin
          if (bus.flush) begin
            state_q <= S_FLUSH;
            ready_q <= 1'b0;
            gen_q   <= 1'b1;
          end else if (bus.req_valid) begin
            state_q <= S_READ;
            ready_q <= 1'b0;
            read_q  <= 1'b1;
            addr_q  <= bus.req_address;
            way_q   <= way_d;
            miss_q  <= ~(bus.req_hit & |bus.req_hit_way);
          end
        end
        S_READ: begin
          state_q <= S_WAIT;
          read_q  <= 1'b0;
        end
        S_WAIT: begin
          state_q      <= S_UPDATE;
          en_q         <= miss_q | ~sat_d;
          line_reset_q <= miss_q ? victim_d : 4'b0000;
          line_sum_q   <= (miss_q | sat_d) ? 4'b0000 : way_q;
          touched_q    <= miss_q ? victim_d : way_q;
        end
        S_UPDATE: begin
          state_q      <= S_RESP;
          en_q         <= 1'b0;
          line_reset_q <= '0;
          line_sum_q   <= '0;
          addr_q       <= '0;
          done_q       <= 1'b1;
          resp_miss_q  <= miss_q;
          victim_way_q <= touched_q;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end
  assign bus.req_ready     = ready_q & ~reset;
  assign bus.done          = done_q & ~reset;
  assign bus.resp_miss     = resp_miss_q & ~reset;
  assign bus.victim_way    = reset ? 4'b0000 : victim_way_q;
  assign cnt_enable_o      = en_q & ~reset;
  assign cnt_line_reset_o  = reset ? 4'b0000 : line_reset_q;
  assign cnt_line_sum_o    = reset ? 4'b0000 : line_sum_q;
  assign cnt_address_o     = reset ? '0 : addr_q;
  assign cnt_read_o        = read_q & ~reset;
  assign cnt_gen_reset_o   = gen_q | reset;
endmodule

// File: tb/tb_lfu_replacement_ctrl.sv
// tb_lfu_replacement_ctrl: table-driven checks of the LFU controller plus flush and mid-update reset sequences
module tb_lfu_replacement_ctrl;
  localparam int BD = 10;
  localparam int SC = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  lfu_replacement_ctrl_if #(.bitsDirect(BD)) bus ();
  logic          en, crd, cgr;
  logic [3:0]    lrst, lsum;
  logic [BD-1:0] caddr;
  logic [SC-1:0] c0, c1, c2, c3;
  lfu_replacement_ctrl #(.bitsDirect(BD), .sizeCounter(SC)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cnt_enable_o(en), .cnt_line_reset_o(lrst), .cnt_line_sum_o(lsum),
    .cnt_address_o(caddr), .cnt_read_o(crd), .cnt_gen_reset_o(cgr),
    .count_in0_i(c0), .count_in1_i(c1), .count_in2_i(c2), .count_in3_i(c3)
  );
  typedef struct {
    logic [BD-1:0] addr;
    logic          hit;
    logic [3:0]    way;
    logic [SC-1:0] k0, k1, k2, k3;
    logic          miss;
    logic [3:0]    vway;
    logic          en;
    logic [3:0]    sum;
    logic [3:0]    rst;
  } vec_t;
  vec_t v[8];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", bus.req_ready, 1);
  endtask
  task automatic apply(input int i);
    bus.req_address = v[i].addr;
    bus.req_hit     = v[i].hit;
    bus.req_hit_way = v[i].way;
    c0 = v[i].k0; c1 = v[i].k1; c2 = v[i].k2; c3 = v[i].k3;
    bus.req_valid   = 1'b1;
  endtask
  task automatic do_txn(input int i, input bit with_flush);
    wait_ready();
    apply(i);
    bus.flush = with_flush;
    if (with_flush) begin
      @(negedge clk);
      chk($sformatf("v%0d flush_gen", i), cgr, 1);
      chk($sformatf("v%0d flush_ready", i), bus.req_ready, 0);
      chk($sformatf("v%0d flush_read", i), crd, 0);
      bus.flush = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d flush_idle_ready", i), bus.req_ready, 1);
      chk($sformatf("v%0d flush_idle_gen", i), cgr, 0);
    end
    @(negedge clk);
    chk($sformatf("v%0d read", i), crd, 1);
    chk($sformatf("v%0d read_addr", i), caddr, v[i].addr);
    chk($sformatf("v%0d busy_ready", i), bus.req_ready, 0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d wait_read", i), crd, 0);
    chk($sformatf("v%0d wait_en", i), en, 0);
    @(negedge clk);
    chk($sformatf("v%0d upd_en", i), en, v[i].en);
    chk($sformatf("v%0d upd_sum", i), lsum, v[i].sum);
    chk($sformatf("v%0d upd_rst", i), lrst, v[i].rst);
    chk($sformatf("v%0d upd_addr", i), caddr, v[i].addr);
    chk($sformatf("v%0d upd_done", i), bus.done, 0);
    @(negedge clk);
    chk($sformatf("v%0d done", i), bus.done, 1);
    chk($sformatf("v%0d resp_miss", i), bus.resp_miss, v[i].miss);
    chk($sformatf("v%0d victim_way", i), bus.victim_way, v[i].vway);
    chk($sformatf("v%0d resp_en", i), en, 0);
    chk($sformatf("v%0d resp_sum_rst", i), {lsum, lrst}, 0);
    @(negedge clk);
    chk($sformatf("v%0d idle_ready", i), bus.req_ready, 1);
    chk($sformatf("v%0d idle_done", i), bus.done, 0);
    chk($sformatf("v%0d hold_victim", i), bus.victim_way, v[i].vway);
    chk($sformatf("v%0d hold_miss", i), bus.resp_miss, v[i].miss);
  endtask
  initial begin
    v[0] = '{10'h015, 1'b1, 4'b0100, 4'd3,  4'd1,  4'd5,  4'd2,  1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000};
    v[1] = '{10'h3FF, 1'b0, 4'b0000, 4'd4,  4'd2,  4'd2,  4'd7,  1'b1, 4'b0010, 1'b1, 4'b0000, 4'b0010};
    v[2] = '{10'h001, 1'b1, 4'b0001, 4'd15, 4'd0,  4'd0,  4'd0,  1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000};
    v[3] = '{10'h2AA, 1'b1, 4'b1010, 4'd0,  4'd14, 4'd0,  4'd0,  1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0000};
    v[4] = '{10'h100, 1'b1, 4'b0000, 4'd9,  4'd9,  4'd9,  4'd9,  1'b1, 4'b0001, 1'b1, 4'b0000, 4'b0001};
    v[5] = '{10'h0F0, 1'b0, 4'b0000, 4'd5,  4'd6,  4'd7,  4'd3,  1'b1, 4'b1000, 1'b1, 4'b0000, 4'b1000};
    v[6] = '{10'h0AB, 1'b1, 4'b1000, 4'd0,  4'd0,  4'd0,  4'd14, 1'b0, 4'b1000, 1'b1, 4'b1000, 4'b0000};
    v[7] = '{10'h155, 1'b0, 4'b0100, 4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 4'b0001, 1'b1, 4'b0000, 4'b0001};
    bus.req_valid = 1'b0; bus.req_address = '0; bus.req_hit = 1'b0; bus.req_hit_way = '0; bus.flush = 1'b0;
    c0 = '0; c1 = '0; c2 = '0; c3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_gen", cgr, 1);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_outs", {en, crd, bus.done, bus.resp_miss, bus.victim_way, lrst, lsum, caddr}, 0);
    reset = 1'b0;
    #1;
    chk("init_gen", cgr, 1);
    chk("init_ready", bus.req_ready, 0);
    @(negedge clk);
    chk("idle_ready", bus.req_ready, 1);
    chk("idle_gen", cgr, 0);
    chk("idle_outs", {en, crd, bus.done, bus.resp_miss, bus.victim_way, lrst, lsum, caddr}, 0);
    for (int i = 0; i < 8; i++) do_txn(i, 1'b0);
    do_txn(5, 1'b1);
    wait_ready();
    apply(0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("ru_read", crd, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ru_en", en, 0);
    chk("ru_strobes", {lsum, lrst}, 0);
    chk("ru_gen", cgr, 1);
    @(negedge clk);
    chk("ru_done", bus.done, 0);
    chk("ru_en2", en, 0);
    reset = 1'b0;
    #1;
    chk("ru_init_gen", cgr, 1);
    chk("ru_init_ready", bus.req_ready, 0);
    chk("ru_init_victim", bus.victim_way, 0);
    @(negedge clk);
    chk("ru_idle_ready", bus.req_ready, 1);
    chk("ru_idle_done", bus.done, 0);
    chk("ru_idle_gen", cgr, 0);
    do_txn(1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
